multicycle_controller: RTL and testbench

- Sequencing FSM for the multi-cycle variant of the MIPS-subset core. Replaces the single-cycle combinational decoder.
- Steps the shared ALU, register file and a single unified instruction/data memory through the phases FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Talks to memory through a req/ready handshake.
- Drives the datapath muxes and write enables, and keeps a count of retired instructions.

---
 rtl/multicycle_controller.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the MIPS-subset core: steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Optional: define ILLEGAL_TRAP_EN to add a TRAP state and the illegal_inst output.
module multicycle_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [31:0]          inst,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alusel,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 jal,
    output logic                 sll,
    output logic                 srl,
    output logic [CNT_WIDTH-1:0] inst_count
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_inst
`endif
);

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b1111;
    localparam logic [3:0] ALU_SLT = 4'b1110;
    localparam logic [3:0] ALU_SLL = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1000;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t     state, next_state;
    logic       retire;
    logic [5:0] opcode, funct;
    logic       is_rtype, r_valid, is_jr, is_lw, is_sw, is_imm, is_branch, is_jump;
    logic [3:0] r_sel, imm_sel;
    logic       unused_inst_bits;

    assign opcode           = inst[31:26];
    assign funct            = inst[5:0];
    assign unused_inst_bits = ^inst[25:6];

    // Instruction classification shared by DECODE and the later phases
    always_comb begin
        is_rtype  = (opcode == 6'h00);
        is_jr     = is_rtype && (funct == 6'h08);
        is_lw     = (opcode == 6'h23);
        is_sw     = (opcode == 6'h2B);
        is_branch = (opcode == 6'h04) || (opcode == 6'h05);
        is_jump   = (opcode == 6'h02) || (opcode == 6'h03) || is_jr;
        r_valid   = 1'b1;
        r_sel     = 4'b0000;
        case (funct)
            6'h20:   r_sel = ALU_ADD;
            6'h22:   r_sel = ALU_SUB;
            6'h24:   r_sel = ALU_AND;
            6'h25:   r_sel = ALU_OR;
            6'h2A:   r_sel = ALU_SLT;
            6'h00:   r_sel = ALU_SLL;
            6'h02:   r_sel = ALU_SRL;
            default: r_valid = 1'b0;
        endcase
        is_imm  = 1'b1;
        imm_sel = 4'b0000;
        case (opcode)
            6'h08, 6'h09: imm_sel = ALU_ADD;
            6'h0C:        imm_sel = ALU_AND;
            6'h0D:        imm_sel = ALU_OR;
            6'h0A:        imm_sel = ALU_SLT;
            default:      is_imm = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= FETCH;
        else       state <= next_state;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       inst_count <= '0;
        else if (retire) inst_count <= inst_count + 1'b1;
    end

    // Outputs are forced low for the whole time reset is asserted, so a pending access is dropped at once
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alusel     = 4'b0000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        jal        = 1'b0;
        sll        = 1'b0;
        srl        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_inst = 1'b0;
`endif
        if (nrst) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    alusel    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) next_state = DECODE;
                end
                DECODE: begin
                    alu_src_b = 2'd3;
                    alusel    = ALU_ADD;
                    if (is_lw || is_sw)                      next_state = MEM_ADDR;
                    else if (is_jump)                        next_state = JUMP;
                    else if ((is_rtype && r_valid) || is_imm) next_state = EXEC;
                    else if (is_branch)                      next_state = BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    else                                     next_state = TRAP;
`else
                    else                                     next_state = FETCH;
`endif
                end
                MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    alusel     = ALU_ADD;
                    next_state = is_lw ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) next_state = MEM_WB;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    next_state = FETCH;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_wr  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    if (is_rtype) begin
                        alu_src_b = 2'd0;
                        alusel    = r_sel;
                        sll       = (funct == 6'h00);
                        srl       = (funct == 6'h02);
                    end else begin
                        alu_src_b = 2'd2;
                        alusel    = imm_sel;
                    end
                    next_state = ALU_WB;
                end
                ALU_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_rtype;
                    retire     = 1'b1;
                    next_state = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alusel     = ALU_SUB;
                    pc_src     = 2'd1;
                    pc_write   = (opcode == 6'h04) ? alu_zero : !alu_zero;
                    retire     = 1'b1;
                    next_state = FETCH;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = is_jr ? 2'd3 : 2'd2;
                    reg_write  = (opcode == 6'h03);
                    jal        = (opcode == 6'h03);
                    retire     = 1'b1;
                    next_state = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    illegal_inst = 1'b1;
                end
`endif
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words are queued, then replayed.
module tb_multicycle_controller;

    localparam int CW = 4;
    localparam logic [3:0] A_ADD = 4'b0001;
    localparam logic [3:0] A_SUB = 4'b0011;
    localparam logic [3:0] A_AND = 4'b0111;
    localparam logic [3:0] A_OR  = 4'b1111;
    localparam logic [3:0] A_SLT = 4'b1110;
    localparam logic [3:0] A_SLL = 4'b1100;
    localparam logic [3:0] A_SRL = 4'b1000;

    typedef logic [19:0] ctl_t;
    typedef struct {
        logic        rdy;
        logic        zero;
        logic [31:0] instr;
        ctl_t        exp;
        string       tag;
    } item_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic [31:0]   inst;
    logic          alu_zero, mem_ready;
    logic          mem_req, mem_wr, iord, ir_write, pc_write;
    logic [1:0]    pc_src, alu_src_b;
    logic          alu_src_a;
    logic [3:0]    alusel;
    logic          reg_write, reg_dst, mem_to_reg, jal, sll, srl;
    logic [CW-1:0] inst_count;
`ifdef ILLEGAL_TRAP_EN
    logic          illegal_inst;
`endif
    ctl_t          obs;
    item_t         sb[$];
    int            n_compared = 0;
    int            n_mismatched = 0;
    int            exp_count = 0;

    multicycle_controller #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .nrst(nrst), .inst(inst), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alusel(alusel),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .jal(jal),
        .sll(sll), .srl(srl), .inst_count(inst_count)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_inst(illegal_inst)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_wr, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  alusel, reg_write, reg_dst, mem_to_reg, jal, sll, srl};

    function automatic ctl_t ctl(input logic req, wr, io, irw, pcw, input logic [1:0] pcs,
                                 input logic asa, input logic [1:0] asb, input logic [3:0] sel,
                                 input logic rw, rdst, m2r, jl, sl, sr);
        return {req, wr, io, irw, pcw, pcs, asa, asb, sel, rw, rdst, m2r, jl, sl, sr};
    endfunction

    function automatic ctl_t c_fetch(input logic rdy);
        return ctl(1, 0, 0, rdy, rdy, 2'd0, 0, 2'd1, A_ADD, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ctl_t c_decode();
        return ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd3, A_ADD, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ctl_t c_exec_r(input logic [3:0] sel, input logic sl, input logic sr);
        return ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, sel, 0, 0, 0, 0, sl, sr);
    endfunction
    function automatic ctl_t c_exec_i(input logic [3:0] sel);
        return ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, sel, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ctl_t c_wb(input logic rdst, input logic m2r);
        return ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 1, rdst, m2r, 0, 0, 0);
    endfunction

    task automatic push(input logic rdy, input logic z, input logic [31:0] i, input ctl_t e, input string tag);
        item_t it;
        it.rdy = rdy; it.zero = z; it.instr = i; it.exp = e; it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic push_front(input logic [31:0] i, input int waits, input string tag);
        for (int k = 0; k < waits; k++) push(1'b0, 1'b0, i, c_fetch(1'b0), {tag, "_fetch_wait"});
        push(1'b1, 1'b0, i, c_fetch(1'b1), {tag, "_fetch"});
        push(1'b0, 1'b0, i, c_decode(), {tag, "_decode"});
    endtask

    task automatic push_r(input logic [31:0] i, input logic [3:0] sel, input logic sl, input logic sr, input string tag);
        push_front(i, 0, tag);
        push(1'b0, 1'b0, i, c_exec_r(sel, sl, sr), {tag, "_exec"});
        push(1'b0, 1'b0, i, c_wb(1'b1, 1'b0), {tag, "_wb"});
        exp_count++;
    endtask

    task automatic push_i(input logic [31:0] i, input logic [3:0] sel, input string tag);
        push_front(i, 0, tag);
        push(1'b0, 1'b0, i, c_exec_i(sel), {tag, "_exec"});
        push(1'b0, 1'b0, i, c_wb(1'b0, 1'b0), {tag, "_wb"});
        exp_count++;
    endtask

    task automatic drain_scoreboard();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            mem_ready = it.rdy;
            alu_zero  = it.zero;
            inst      = it.instr;
            #1;
            n_compared++;
            if (obs !== it.exp) begin
                n_mismatched++;
                $display("[TB] FAIL %s: controls got %05h want %05h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_count(input string tag);
        idle_cycle();
        n_compared++;
        if (inst_count !== CW'(exp_count)) begin
            n_mismatched++;
            $display("[TB] FAIL %s_count: got %0d want %0d", tag, inst_count, CW'(exp_count));
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0; inst = 32'h0;
        #3;
        n_compared++;
        if (obs !== 20'h0 || inst_count !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got ctl %05h cnt %0d want 0 0", obs, inst_count);
        end
        @(negedge clk);
        nrst = 1'b1; mem_ready = 1'b0;
        #1;
        n_compared++;
        if (obs !== c_fetch(1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release: got %05h want %05h", obs, c_fetch(1'b0));
        end
    endtask

    task automatic test_r_type();
        push_front(32'h00221820, 1, "add");
        push(1'b0, 1'b0, 32'h00221820, c_exec_r(A_ADD, 0, 0), "add_exec");
        push(1'b0, 1'b0, 32'h00221820, c_wb(1'b1, 1'b0), "add_wb");
        exp_count++;
        drain_scoreboard();
        test_count("add");
    endtask

    task automatic test_shift();
        push_r(32'h00011080, A_SLL, 1'b1, 1'b0, "sll");
        push_r(32'h00011082, A_SRL, 1'b0, 1'b1, "srl");
        drain_scoreboard();
        test_count("shift");
    endtask

    task automatic test_i_type();
        push_i(32'h34220005, A_OR, "ori");
        push_i(32'h28220005, A_SLT, "slti");
        push_i(32'h30220005, A_AND, "andi");
        drain_scoreboard();
        test_count("itype");
    endtask

    task automatic test_load();
        push_front(32'h8C220008, 0, "lw");
        push(1'b0, 1'b0, 32'h8C220008, c_exec_i(A_ADD), "lw_addr");
        push(1'b0, 1'b0, 32'h8C220008, ctl(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 0), "lw_rd_wait1");
        push(1'b0, 1'b0, 32'h8C220008, ctl(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 0), "lw_rd_wait2");
        push(1'b1, 1'b0, 32'h8C220008, ctl(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 0), "lw_rd_done");
        push(1'b0, 1'b0, 32'h8C220008, c_wb(1'b0, 1'b1), "lw_wb");
        exp_count++;
        drain_scoreboard();
        test_count("lw");
    endtask

    task automatic test_store();
        push_front(32'hAC220008, 0, "sw");
        push(1'b0, 1'b0, 32'hAC220008, c_exec_i(A_ADD), "sw_addr");
        push(1'b1, 1'b0, 32'hAC220008, ctl(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 0), "sw_wr");
        exp_count++;
        drain_scoreboard();
        test_count("sw");
    endtask

    task automatic test_branch();
        logic [31:0] op [4] = '{32'h10220004, 32'h10220004, 32'h14220004, 32'h14220004};
        logic        zf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        tk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            push_front(op[k], 0, $sformatf("br%0d", k));
            push(1'b0, zf[k], op[k], ctl(0, 0, 0, 0, tk[k], 2'd1, 1, 2'd0, A_SUB, 0, 0, 0, 0, 0, 0),
                 $sformatf("br%0d_branch", k));
            exp_count++;
        end
        drain_scoreboard();
        test_count("branch");
    endtask

    task automatic test_jump();
        push_front(32'h0C000010, 0, "jal");
        push(1'b0, 1'b0, 32'h0C000010, ctl(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 4'b0000, 1, 0, 0, 1, 0, 0), "jal_jump");
        push_front(32'h03E00008, 0, "jr");
        push(1'b0, 1'b0, 32'h03E00008, ctl(0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 0), "jr_jump");
        push_front(32'h08000010, 0, "j");
        push(1'b0, 1'b0, 32'h08000010, ctl(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 0), "j_jump");
        exp_count += 3;
        drain_scoreboard();
        test_count("jump");
    endtask

    task automatic test_back_to_back();
        push_r(32'h00221820, A_ADD, 1'b0, 1'b0, "b2b_add");
        push_r(32'h00221822, A_SUB, 1'b0, 1'b0, "b2b_sub");
        push_r(32'h00221824, A_AND, 1'b0, 1'b0, "b2b_and");
        drain_scoreboard();
        test_count("b2b_wrap");
    endtask

    task automatic test_reset_mid_write();
        push_front(32'hAC220008, 0, "rst_sw");
        push(1'b0, 1'b0, 32'hAC220008, c_exec_i(A_ADD), "rst_sw_addr");
        push(1'b0, 1'b0, 32'hAC220008, ctl(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 0), "rst_sw_wait");
        drain_scoreboard();
        #2;
        nrst = 1'b0;
        mem_ready = 1'b1;
        #1;
        exp_count = 0;
        n_compared++;
        if (mem_req !== 1'b0 || obs !== 20'h0 || inst_count !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_outputs: got ctl %05h cnt %0d want 0 0", obs, inst_count);
        end
        @(negedge clk);
        nrst = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_compared++;
        if (obs !== c_fetch(1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid_restart: got %05h want %05h", obs, c_fetch(1'b0));
        end
        test_count("rst_mid");
    endtask

    task automatic test_illegal();
        push_r(32'h00221820, A_ADD, 1'b0, 1'b0, "pre_add");
        push_front(32'hFC000000, 0, "ill");
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) push(1'b1, 1'b0, 32'hFC000000, 20'h0, "ill_trap");
        drain_scoreboard();
        n_compared++;
        if (illegal_inst !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ill_flag: got %b want 1", illegal_inst);
        end
        test_count("ill");
        nrst = 1'b0;
        #1;
        n_compared++;
        if (illegal_inst !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ill_flag_reset: got %b want 0", illegal_inst);
        end
        @(negedge clk);
        nrst = 1'b1;
`else
        push(1'b0, 1'b0, 32'hFC000000, c_fetch(1'b0), "ill_nop_fetch");
        drain_scoreboard();
        test_count("ill");
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_r_type();
        test_shift();
        test_i_type();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_back_to_back();
        test_reset_mid_write();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
